// File: rtl/cam_requester.sv
// cam_requester: initiator-side engine for the CAM read/write/search port set.
// Accepts one command at a time, pulses the matching CAM strobe for one cycle,
// waits (bounded by TIMEOUT) for the CAM result, then returns one response.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_op_i                    00 read, 01 write, 10 search, 11 reserved
//   cmd_index_i, cmd_data_i     read/write index, write data / search key
//   read_o, read_index_o        CAM read strobe and index
//   write_o, write_index_o,
//   write_data_o                CAM write strobe, index and data
//   search_o, search_data_o     CAM search strobe and key
//   read_valid_i, read_value_i  CAM read result
//   search_valid_i,
//   search_index_i              CAM search hit and hit index
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_op_o, rsp_hit_o,
//   rsp_data_o, rsp_timeout_o,
//   rsp_err_o                   response payload
//   busy_o                      engine not idle
module cam_requester #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned INDEX_WIDTH = 5,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_op_i,
  input  logic [INDEX_WIDTH-1:0] cmd_index_i,
  input  logic [DATA_WIDTH-1:0]  cmd_data_i,
  output logic                   read_o,
  output logic [INDEX_WIDTH-1:0] read_index_o,
  output logic                   write_o,
  output logic [INDEX_WIDTH-1:0] write_index_o,
  output logic [DATA_WIDTH-1:0]  write_data_o,
  output logic                   search_o,
  output logic [DATA_WIDTH-1:0]  search_data_o,
  input  logic                   read_valid_i,
  input  logic [DATA_WIDTH-1:0]  read_value_i,
  input  logic                   search_valid_i,
  input  logic [INDEX_WIDTH-1:0] search_index_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [1:0]             rsp_op_o,
  output logic                   rsp_hit_o,
  output logic [DATA_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_timeout_o,
  output logic                   rsp_err_o,
  output logic                   busy_o
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] OP_READ   = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_SEARCH = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic                   cmd_ready_d, busy_d;
  logic                   read_d, write_d, search_d;
  logic [INDEX_WIDTH-1:0] read_index_d, write_index_d;
  logic [DATA_WIDTH-1:0]  write_data_d, search_data_d;
  logic                   rsp_valid_d, rsp_hit_d, rsp_timeout_d, rsp_err_d;
  logic [1:0]             rsp_op_d;
  logic [DATA_WIDTH-1:0]  rsp_data_d;
  logic                   result_valid;

  // Only the valid that belongs to the in-flight op is honoured.
  assign result_valid = (op_q == OP_READ) ? read_valid_i : search_valid_i;

  // Next-state and next-output logic; outputs are precomputed so they are
  // registered in the same edge as the state change.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    read_d        = 1'b0;
    write_d       = 1'b0;
    search_d      = 1'b0;
    read_index_d  = read_index_o;
    write_index_d = write_index_o;
    write_data_d  = write_data_o;
    search_data_d = search_data_o;
    rsp_valid_d   = rsp_valid_o;
    rsp_op_d      = rsp_op_o;
    rsp_hit_d     = rsp_hit_o;
    rsp_data_d    = rsp_data_o;
    rsp_timeout_d = rsp_timeout_o;
    rsp_err_d     = rsp_err_o;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          op_d          = cmd_op_i;
          read_index_d  = cmd_index_i;
          write_index_d = cmd_index_i;
          write_data_d  = cmd_data_i;
          search_data_d = cmd_data_i;
          read_d        = (cmd_op_i == OP_READ);
          write_d       = (cmd_op_i == OP_WRITE);
          search_d      = (cmd_op_i == OP_SEARCH);
          state_d       = S_ISSUE;
        end
      end

      // Reserved ops pass through ISSUE without a strobe so write and
      // reserved answers share the same two-cycle latency.
      S_ISSUE: begin
        if (op_q == OP_WRITE || op_q == OP_RSVD) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_op_d      = op_q;
          rsp_hit_d     = (op_q == OP_WRITE);
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          rsp_err_d     = (op_q == OP_RSVD);
        end else begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end

      // A valid in the final counted cycle still wins over the timeout.
      S_WAIT: begin
        if (result_valid) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_op_d      = op_q;
          rsp_hit_d     = 1'b1;
          rsp_data_d    = (op_q == OP_READ) ? read_value_i
                                            : DATA_WIDTH'(search_index_i);
          rsp_timeout_d = 1'b0;
          rsp_err_d     = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          rsp_op_d      = op_q;
          rsp_hit_d     = 1'b0;
          rsp_data_d    = '0;
          rsp_timeout_d = (op_q == OP_READ);
          rsp_err_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready_i) begin
          state_d       = S_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_op_d      = '0;
          rsp_hit_d     = 1'b0;
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b0;
          rsp_err_d     = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State, context and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= '0;
      cnt_q         <= '0;
      cmd_ready_o   <= 1'b1;
      busy_o        <= 1'b0;
      read_o        <= 1'b0;
      write_o       <= 1'b0;
      search_o      <= 1'b0;
      read_index_o  <= '0;
      write_index_o <= '0;
      write_data_o  <= '0;
      search_data_o <= '0;
      rsp_valid_o   <= 1'b0;
      rsp_op_o      <= '0;
      rsp_hit_o     <= 1'b0;
      rsp_data_o    <= '0;
      rsp_timeout_o <= 1'b0;
      rsp_err_o     <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      cmd_ready_o   <= cmd_ready_d;
      busy_o        <= busy_d;
      read_o        <= read_d;
      write_o       <= write_d;
      search_o      <= search_d;
      read_index_o  <= read_index_d;
      write_index_o <= write_index_d;
      write_data_o  <= write_data_d;
      search_data_o <= search_data_d;
      rsp_valid_o   <= rsp_valid_d;
      rsp_op_o      <= rsp_op_d;
      rsp_hit_o     <= rsp_hit_d;
      rsp_data_o    <= rsp_data_d;
      rsp_timeout_o <= rsp_timeout_d;
      rsp_err_o     <= rsp_err_d;
    end
  end

endmodule
